// File: rtl/lm32_condition_stage_if.sv
// ============================================================================
// Module      : lm32_condition_stage_if
// Description : X-stage inputs, pipeline control and M-stage outputs of the
//               condition stage bundled as one interface.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface lm32_condition_stage_if #(
    parameter int WORD_WIDTH = 32,
    parameter int STAT_WIDTH = 16
);
    logic                  valid_x;
    logic                  stall_x;
    logic                  stall_m;
    logic                  kill_x;
    logic                  kill_m;
    logic [WORD_WIDTH-1:0] adder_result_x;
    logic                  adder_carry_n_x;
    logic                  adder_overflow_x;
    logic                  compare_x;
    logic                  branch_x;
    logic [2:0]            condition_x;
    logic                  predict_taken_x;
    logic                  stats_clr;

    logic                  valid_m;
    logic [WORD_WIDTH-1:0] result_m;
    logic                  condition_met_m;
    logic                  branch_taken_m;
    logic                  mispredict_m;
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output valid_x, stall_x, stall_m, kill_x, kill_m, adder_result_x,
               adder_carry_n_x, adder_overflow_x, compare_x, branch_x,
               condition_x, predict_taken_x, stats_clr,
        input  valid_m, result_m, condition_met_m, branch_taken_m,
               mispredict_m, branch_count, mispredict_count
    );

    modport slave (
        input  valid_x, stall_x, stall_m, kill_x, kill_m, adder_result_x,
               adder_carry_n_x, adder_overflow_x, compare_x, branch_x,
               condition_x, predict_taken_x, stats_clr,
        output valid_m, result_m, condition_met_m, branch_taken_m,
               mispredict_m, branch_count, mispredict_count
    );
endinterface

`default_nettype wire

// File: rtl/lm32_condition_stage.sv
// ============================================================================
// Module      : lm32_condition_stage
// Description : X->M register after the adder; evaluates compare/branch
//               conditions in M. Optional branch statistics: CFG_BRANCH_STATS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lm32_condition_stage #(
    parameter int WORD_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    lm32_condition_stage_if.slave bus
);

    localparam logic [2:0] C_COND_EQ     = 3'b000;
    localparam logic [2:0] C_COND_NE     = 3'b001;
    localparam logic [2:0] C_COND_GT     = 3'b010;
    localparam logic [2:0] C_COND_GE     = 3'b011;
    localparam logic [2:0] C_COND_GTU    = 3'b100;
    localparam logic [2:0] C_COND_GEU    = 3'b101;
    localparam logic [2:0] C_COND_ALWAYS = 3'b110;

    logic                  valid_q,     valid_d;
    logic [WORD_WIDTH-1:0] result_q,    result_d;
    logic                  carry_n_q,   carry_n_d;
    logic                  overflow_q,  overflow_d;
    logic                  compare_q,   compare_d;
    logic                  branch_q,    branch_d;
    logic [2:0]            condition_q, condition_d;
    logic                  predict_q,   predict_d;

    logic zero;
    logic signed_ge;
    logic condition_met;
    logic mispredict;
    logic retire;

    always_comb begin
        valid_d     = valid_q & ~bus.kill_m;
        result_d    = result_q;
        carry_n_d   = carry_n_q;
        overflow_d  = overflow_q;
        compare_d   = compare_q;
        branch_d    = branch_q;
        condition_d = condition_q;
        predict_d   = predict_q;
        if (!bus.stall_m) begin
            valid_d     = bus.valid_x & ~bus.stall_x & ~bus.kill_x;
            result_d    = bus.adder_result_x;
            carry_n_d   = bus.adder_carry_n_x;
            overflow_d  = bus.adder_overflow_x;
            compare_d   = bus.compare_x;
            branch_d    = bus.branch_x;
            condition_d = bus.condition_x;
            predict_d   = bus.predict_taken_x;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            carry_n_q   <= 1'b0;
            overflow_q  <= 1'b0;
            compare_q   <= 1'b0;
            branch_q    <= 1'b0;
            condition_q <= C_COND_EQ;
            predict_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            carry_n_q   <= carry_n_d;
            overflow_q  <= overflow_d;
            compare_q   <= compare_d;
            branch_q    <= branch_d;
            condition_q <= condition_d;
            predict_q   <= predict_d;
        end
    end

    // Signed GE: sign of the difference corrected by overflow
    always_comb begin
        zero      = (result_q == '0);
        signed_ge = (result_q[WORD_WIDTH-1] == overflow_q);
        case (condition_q)
            C_COND_EQ:     condition_met = zero;
            C_COND_NE:     condition_met = ~zero;
            C_COND_GT:     condition_met = signed_ge & ~zero;
            C_COND_GE:     condition_met = signed_ge;
            C_COND_GTU:    condition_met = carry_n_q & ~zero;
            C_COND_GEU:    condition_met = carry_n_q;
            C_COND_ALWAYS: condition_met = 1'b1;
            default:       condition_met = 1'b0;
        endcase
    end

    assign mispredict = valid_q & branch_q & (condition_met != predict_q);
    assign retire     = valid_q & ~bus.stall_m & ~bus.kill_m;

    assign bus.valid_m         = valid_q;
    assign bus.result_m        = compare_q ? {{(WORD_WIDTH-1){1'b0}}, condition_met} : result_q;
    assign bus.condition_met_m = condition_met;
    assign bus.branch_taken_m  = valid_q & branch_q & condition_met;
    assign bus.mispredict_m    = mispredict;

`ifdef CFG_BRANCH_STATS_EN
    logic [STAT_WIDTH-1:0] branch_count_q,     branch_count_d;
    logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    // Clear has priority over a same-cycle increment; both saturate
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bus.stats_clr) begin
            branch_count_d     = '0;
            mispredict_count_d = '0;
        end else if (retire && branch_q) begin
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + 1'b1;
            end
            if (mispredict && (mispredict_count_q != '1)) begin
                mispredict_count_d = mispredict_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;
`else
    logic unused_stats;
    assign unused_stats         = bus.stats_clr ^ retire;
    assign bus.branch_count     = '0;
    assign bus.mispredict_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lm32_condition_stage.sv
// ============================================================================
// Module      : tb_lm32_condition_stage
// Description : Randomized and directed bench for lm32_condition_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_lm32_condition_stage;

    localparam int WW = 32;
    localparam int SW = 16;
    localparam int STAT_MAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lm32_condition_stage_if #(.WORD_WIDTH(WW), .STAT_WIDTH(SW)) bus ();

    lm32_condition_stage #(.WORD_WIDTH(WW), .STAT_WIDTH(SW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference: contents of the M stage as an abstract instruction record
    typedef struct {
        bit           valid;
        bit [WW-1:0]  res;
        bit           cn;
        bit           ov;
        bit           cmp;
        bit           br;
        bit [2:0]     cond;
        bit           pred;
    } minst_t;

    minst_t m;
    int     bcnt;
    int     mcnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit eval_cond(input bit [2:0] c, input bit [WW-1:0] r, input bit cn, input bit ov);
        longint signed sres;
        bit is_zero;
        bit ge_s;
        is_zero = (r == 0);
        sres    = longint'($signed(r));
        ge_s    = ((sres < 0) == ov);
        case (c)
            3'd0: return is_zero;
            3'd1: return !is_zero;
            3'd2: return ge_s && !is_zero;
            3'd3: return ge_s;
            3'd4: return cn && !is_zero;
            3'd5: return cn;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_met();
        return eval_cond(m.cond, m.res, m.cn, m.ov);
    endfunction

    function automatic bit model_mis();
        return m.valid && m.br && (model_met() != m.pred);
    endfunction

    task automatic model_reset();
        m = '{valid: 0, res: 0, cn: 0, ov: 0, cmp: 0, br: 0, cond: 3'd0, pred: 0};
        bcnt = 0;
        mcnt = 0;
    endtask

    task automatic model_advance();
        bit retire;
        bit mis;
        retire = m.valid && !bus.stall_m && !bus.kill_m;
        mis    = model_mis();
        if (bus.stats_clr) begin
            bcnt = 0;
            mcnt = 0;
        end else if (retire && m.br) begin
            if (bcnt < STAT_MAX) bcnt++;
            if (mis && mcnt < STAT_MAX) mcnt++;
        end
        if (bus.stall_m) begin
            if (bus.kill_m) m.valid = 0;
        end else begin
            m.valid = bus.valid_x && !bus.stall_x && !bus.kill_x;
            m.res   = bus.adder_result_x;
            m.cn    = bus.adder_carry_n_x;
            m.ov    = bus.adder_overflow_x;
            m.cmp   = bus.compare_x;
            m.br    = bus.branch_x;
            m.cond  = bus.condition_x;
            m.pred  = bus.predict_taken_x;
        end
    endtask

    task automatic check_all();
        bit met;
        met = model_met();
        check("valid_m", 64'(bus.valid_m), 64'(m.valid));
        check("result_m", 64'(bus.result_m), m.cmp ? 64'(met) : 64'(m.res));
        check("condition_met_m", 64'(bus.condition_met_m), 64'(met));
        check("branch_taken_m", 64'(bus.branch_taken_m), 64'(m.valid && m.br && met));
        check("mispredict_m", 64'(bus.mispredict_m), 64'(model_mis()));
`ifdef CFG_BRANCH_STATS_EN
        check("branch_count", 64'(bus.branch_count), 64'(bcnt));
        check("mispredict_count", 64'(bus.mispredict_count), 64'(mcnt));
`else
        check("branch_count", 64'(bus.branch_count), 64'd0);
        check("mispredict_count", 64'(bus.mispredict_count), 64'd0);
`endif
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ctl(input bit vx, input bit sx, input bit sm, input bit kx, input bit km, input bit clr);
        bus.valid_x   = vx;
        bus.stall_x   = sx;
        bus.stall_m   = sm;
        bus.kill_x    = kx;
        bus.kill_m    = km;
        bus.stats_clr = clr;
    endtask

    task automatic set_x(input bit [WW-1:0] r, input bit cn, input bit ov, input bit cmp,
                         input bit br, input bit [2:0] c, input bit pred);
        bus.adder_result_x   = r;
        bus.adder_carry_n_x  = cn;
        bus.adder_overflow_x = ov;
        bus.compare_x        = cmp;
        bus.branch_x         = br;
        bus.condition_x      = c;
        bus.predict_taken_x  = pred;
    endtask

    task automatic rand_x();
        bit [WW-1:0] r;
        case ($urandom_range(0, 3))
            0: r = 0;
            1: r = 32'h8000_0000;
            2: r = 32'hFFFF_FFFF;
            default: r = $urandom;
        endcase
        set_x(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), 1'($urandom));
    endtask

    logic [WW-1:0] held_result;

    initial begin
        model_reset();
        set_ctl(0, 0, 0, 0, 0, 0);
        set_x(0, 0, 0, 0, 0, 3'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_m", 64'(bus.valid_m), 64'd0);
        check("rst_result_m", 64'(bus.result_m), 64'd0);
        check("rst_condition_met_m", 64'(bus.condition_met_m), 64'd1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Compare EQ on a zero difference
        set_ctl(1, 0, 0, 0, 0, 0);
        set_x(32'h0, 1, 0, 1, 0, 3'd0, 0);
        step();
        check("cmp_eq_valid", 64'(bus.valid_m), 64'd1);
        check("cmp_eq_result", 64'(bus.result_m), 64'h1);

        // Signed GT with overflow, predicted not taken
        set_x(32'h8000_0000, 0, 1, 0, 1, 3'd2, 0);
        step();
        check("gt_met", 64'(bus.condition_met_m), 64'd1);
        check("gt_taken", 64'(bus.branch_taken_m), 64'd1);
        check("gt_mispredict", 64'(bus.mispredict_m), 64'd1);
        set_x(32'h8000_0000, 0, 1, 0, 1, 3'd4, 0);
        step();
        check("gtu_met", 64'(bus.condition_met_m), 64'd0);
        check("gtu_mispredict", 64'(bus.mispredict_m), 64'd0);

        // stall_m holds M for three cycles while X keeps changing
        held_result = bus.result_m;
        set_ctl(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            rand_x();
            step();
            check("stall_hold_result", 64'(bus.result_m), 64'(held_result));
        end
        set_ctl(1, 0, 0, 0, 0, 0);
        set_x(32'h1234_5678, 1, 0, 0, 0, 3'd1, 0);
        step();
        check("release_result", 64'(bus.result_m), 64'h1234_5678);
        check("release_valid", 64'(bus.valid_m), 64'd1);

        // Bubble from stall_x, then kill_m under stall_m
        set_ctl(1, 1, 0, 0, 0, 0);
        step();
        check("bubble_valid", 64'(bus.valid_m), 64'd0);
        set_ctl(1, 0, 0, 0, 0, 0);
        set_x(32'hCAFE_0001, 1, 0, 0, 0, 3'd1, 0);
        step();
        set_ctl(1, 0, 1, 1, 1, 0);
        rand_x();
        step();
        check("kill_stall_valid", 64'(bus.valid_m), 64'd0);
        check("kill_stall_result", 64'(bus.result_m), 64'hCAFE_0001);

        // Asynchronous reset mid-cycle with a live M instruction
        set_ctl(1, 0, 1, 0, 0, 0);
        set_x(32'h0000_00AB, 1, 0, 0, 1, 3'd6, 1);
        bus.stall_m = 0;
        step();
        bus.stall_m = 1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.valid_m), 64'd0);
        check("async_rst_result", 64'(bus.result_m), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_ctl(1'($urandom_range(0, 3) != 0), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
            rand_x();
            step();
        end

`ifdef CFG_BRANCH_STATS_EN
        set_ctl(0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 'hFFFE + 5; i++) begin
            set_ctl(1, 0, 0, 0, 0, 0);
            set_x(32'h1, 1, 0, 0, 1, 3'd6, (i == 10 || i == 100 || i == 1000) ? 1'b0 : 1'b1);
            step();
        end
        set_ctl(0, 0, 0, 0, 0, 0);
        step();
        check("stats_sat_branch", 64'(bus.branch_count), 64'hFFFF);
        check("stats_mispredict", 64'(bus.mispredict_count), 64'd3);
        set_ctl(1, 0, 0, 0, 0, 0);
        set_x(32'h1, 1, 0, 0, 1, 3'd6, 0);
        step();
        set_ctl(0, 0, 0, 0, 0, 1);
        step();
        check("stats_clr_branch", 64'(bus.branch_count), 64'd0);
        check("stats_clr_mispredict", 64'(bus.mispredict_count), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lm32_condition_stage.md
# lm32_condition_stage

X→M pipeline stage directly downstream of the integer adder/subtractor. Registers the X-stage adder result, inverted carry and overflow flag. Evaluates the compare condition on those registered flags, and produces in M:
- compare result,
- branch-taken flag,
- branch-mispredict flag.

Includes stall/kill handshake with the pipeline controller and optional branch statistics counters.

## Interface
Parameters:
- WORD_WIDTH, 32, datapath width; must match adder width.
- STAT_WIDTH, 16, width of each statistics counter (used only with CFG_BRANCH_STATS_EN).

Ports:
- clk_i  in  1  pipeline clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- valid_x  in  1  X-stage holds a live instruction.
- stall_x  in  1  X-stage is stalled; its contents must not advance.
- stall_m  in  1  M-stage is stalled; M register holds.
- kill_x  in  1  squash the X-stage instruction.
- kill_m  in  1  squash the M-stage instruction.
- adder_result_x  in  WORD_WIDTH  adder sum/difference.
- adder_carry_n_x  in  1  inverted carry; 1 = operand_0 ≥ operand_1 (unsigned) on subtract.
- adder_overflow_x  in  1  signed overflow on subtract.
- compare_x  in  1  instruction is a compare (writes 0/1).
- branch_x  in  1  instruction is a conditional branch.
- condition_x  in  3  condition code:
  - 000 EQ, 001 NE, 010 GT, 011 GE, 100 GTU, 101 GEU, 110 ALWAYS, 111 NEVER.
- predict_taken_x  in  1  fetch predicted this branch taken.
- stats_clr  in  1  synchronous clear of statistics counters.
- valid_m  out  1  M-stage holds a live instruction.
- result_m  out  WORD_WIDTH  compare: zero-extended condition bit; otherwise registered adder result.
- condition_met_m  out  1  evaluated condition.
- branch_taken_m  out  1  valid_m & branch_m & condition_met_m.
- mispredict_m  out  1  valid_m & branch_m & (condition_met_m != predict_taken_m).
- branch_count  out  STAT_WIDTH  retired conditional branches.
- mispredict_count  out  STAT_WIDTH  retired mispredicted branches.

## Operation
M register advance:
- Register set: valid, result, carry_n, overflow, compare, branch, condition, predict.
- Loads when stall_m=0.
- Loaded valid = valid_x & !stall_x & !kill_x.
- If stall_x=1 while stall_m=0, a bubble is inserted (valid_m←0); payload fields may load but are don't-care.
- When stall_m=1, all M fields hold. kill_m=1 still forces valid_m←0 at the next edge.
- kill_x with stall_m=1: no effect on M.

Condition evaluation (combinational from M register):
- zero = (result_reg == 0); negative = result_reg[WORD_WIDTH-1].
- EQ = zero; NE = !zero.
- GE = (negative == overflow); GT = GE & !zero.
- GEU = carry_n; GTU = carry_n & !zero.
- ALWAYS = 1; NEVER = 0.

Output qualification:
- result_m = compare_reg ? {WORD_WIDTH-1 zeros, condition_met_m} : result_reg.
- branch_taken_m and mispredict_m are gated by valid_m.
- All outputs are independent of kill_m in the current cycle; kill_m takes effect on the next edge.

Retire event: valid_m & !stall_m & !kill_m.

## Timing
- Latency: one cycle, X inputs → M outputs.
- Outputs registered or derived from registers only; no X→M combinational path.
- Reset (async assert, sync-released by system): valid_m=0, result_m=0, condition_met_m=1 (EQ on zero result), branch_taken_m=0, mispredict_m=0, counters=0.
- Reset asserted mid-stall: all state cleared immediately, regardless of stall_m.
- Simultaneous stall_m=1 and kill_m=1: kill wins for valid; payload holds.

## Configuration
Macro CFG_BRANCH_STATS_EN.

Defined:
- Two STAT_WIDTH counters.
- On each retire with branch_reg=1: branch_count increments.
- If that branch is also mispredicted: mispredict_count increments in the same cycle.
- Each counter saturates at all-ones.
- stats_clr=1 clears both counters at the next edge and overrides a same-cycle increment.

Undefined:
- Counters and their logic absent.
- branch_count and mispredict_count tie to 0.
- stats_clr ignored.

## Test plan
- Reset, then SUB result 0x00000000, carry_n=1, ovf=0, compare, cond=EQ → next cycle: valid_m=1, result_m=0x00000001, condition_met_m=1.
- Branch GT signed: result=0x80000000, ovf=1, carry_n=0, predict_taken=0 → condition_met_m=1, branch_taken_m=1, mispredict_m=1. Repeat with cond GTU → condition_met_m=0, mispredict_m=0.
- stall_m=1 for 3 cycles with new X data each cycle → M outputs unchanged. Release → M takes X data presented on the release cycle.
- stall_x=1, stall_m=0 → valid_m=0 bubble. kill_m=1 during stall_m=1 → valid_m=0 after the edge, result_m unchanged.
- Async reset asserted mid-cycle with valid_m=1 → valid_m=0 and result_m=0 without waiting for a clock edge.
- With CFG_BRANCH_STATS_EN:
  - 0xFFFE branches retired, 3 of them mispredicted, then 5 more branches → branch_count=0xFFFF (saturated), mispredict_count=3.
  - Then stats_clr together with a retiring branch → both counters 0.
